// File: rtl/mesh_job_sequencer.sv
// Initiator for one matrix-vector job on the weight-stationary mesh: preload, start, wait, drain results.
// Define MESH_SEQ_SAT_EN for signed saturation ACC_W->OUT_W; otherwise results are truncated.
module mesh_job_sequencer #(
  parameter int DW       = 8,
  parameter int ROWS     = 8,
  parameter int COLS     = 16,
  parameter int ROW_W    = 3,
  parameter int COL_W    = 4,
  parameter int ACC_W    = 16,
  parameter int OUT_W    = 16,
  parameter int COMP_LAT = 29
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COLS*DW-1:0]       cmd_x,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [DW-1:0]            w_data,
  output logic                     preload_valid,
  output logic [ROW_W+COL_W-1:0]   preload_addr,
  output logic [DW-1:0]            preload_data,
  output logic                     start,
  output logic [COLS*DW-1:0]       x_vector_flat,
  input  logic [ROWS*ACC_W-1:0]    result_flat,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ROW_W-1:0]         res_row,
  output logic [OUT_W-1:0]         res_data,
  output logic                     res_last,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FIRE  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int CNT_W = $clog2(COMP_LAT + 1);

  logic [2:0]             state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic [ROW_W-1:0]       idx_q, idx_d;
  logic [COLS*DW-1:0]     x_q, x_d;
  logic                   pv_q, pv_d;
  logic [ROW_W+COL_W-1:0] pa_q, pa_d;
  logic [DW-1:0]          pd_q, pd_d;
  logic                   start_q, start_d;
  logic                   cap_en;
  logic [ACC_W-1:0]       cap_q [ROWS];
  logic                   drain;

  function automatic logic [OUT_W-1:0] to_out(input logic [ACC_W-1:0] v);
`ifdef MESH_SEQ_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if ($signed(v) > sat_max)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if ($signed(v) < sat_min) return {1'b1, {(OUT_W-1){1'b0}}};
    else                           return OUT_W'(v);
`else
    return OUT_W'(v);
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    x_d     = x_q;
    pv_d    = 1'b0;
    pa_d    = pa_q;
    pd_d    = pd_q;
    start_d = 1'b0;
    cap_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_valid) begin
          pv_d = 1'b1;
          pa_d = {row_q, col_q};
          pd_d = w_data;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_W'(ROWS - 1)) state_d = S_FIRE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FIRE: begin
        start_d = 1'b1;
        lat_d   = CNT_W'(COMP_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // capture one edge after the count hits zero so result_flat has settled
        if (lat_q == '0) begin
          cap_en  = 1'b1;
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (idx_q == ROW_W'(ROWS - 1)) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      pv_q    <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROWS; i++) cap_q[i] <= '0;
    end else if (cap_en) begin
      for (int unsigned i = 0; i < ROWS; i++) cap_q[i] <= result_flat[i*ACC_W +: ACC_W];
    end
  end

  assign drain         = (state_q == S_DRAIN);
  assign cmd_ready     = (state_q == S_IDLE);
  assign w_ready       = (state_q == S_LOAD);
  assign busy          = (state_q != S_IDLE);
  assign preload_valid = pv_q;
  assign preload_addr  = pa_q;
  assign preload_data  = pd_q;
  assign start         = start_q;
  assign x_vector_flat = x_q;
  assign res_valid     = drain;
  assign res_row       = idx_q;
  assign res_data      = drain ? to_out(cap_q[idx_q]) : '0;
  assign res_last      = drain && (idx_q == ROW_W'(ROWS - 1));

endmodule

// File: tb/tb_mesh_job_sequencer.sv
// Bench for mesh_job_sequencer: directed jobs, a behavioural mesh stub, and a per-cycle reference model.
`timescale 1ns/1ps
module tb_mesh_job_sequencer;
  localparam int DW = 8, ROWS = 8, COLS = 16, ROW_W = 3, COL_W = 4, ACC_W = 16, COMP_LAT = 29;
  localparam int NW = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   cmd_valid, w_valid, res_ready;
  logic [COLS*DW-1:0]     cmd_x;
  logic [DW-1:0]          w_data;
  logic [ROWS*ACC_W-1:0]  result_flat;

  logic                   cmd_ready, w_ready, preload_valid, start, res_valid, res_last, busy;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0]          preload_data;
  logic [COLS*DW-1:0]     x_vector_flat;
  logic [ROW_W-1:0]       res_row;
  logic [15:0]            res_data;

  logic                   b_cmd_ready, b_w_ready, b_preload_valid, b_start, b_res_valid, b_res_last, b_busy;
  logic [ROW_W+COL_W-1:0] b_preload_addr;
  logic [DW-1:0]          b_preload_data;
  logic [COLS*DW-1:0]     b_x_vector_flat;
  logic [ROW_W-1:0]       b_res_row;
  logic [7:0]             b_res_data;

  mesh_job_sequencer #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
                       .ACC_W(ACC_W), .OUT_W(16), .COMP_LAT(COMP_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .preload_valid(preload_valid), .preload_addr(preload_addr), .preload_data(preload_data),
    .start(start), .x_vector_flat(x_vector_flat), .result_flat(result_flat),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data),
    .res_last(res_last), .busy(busy));

  mesh_job_sequencer #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
                       .ACC_W(ACC_W), .OUT_W(8), .COMP_LAT(COMP_LAT)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_x(cmd_x),
    .w_valid(w_valid), .w_ready(b_w_ready), .w_data(w_data),
    .preload_valid(b_preload_valid), .preload_addr(b_preload_addr), .preload_data(b_preload_data),
    .start(b_start), .x_vector_flat(b_x_vector_flat), .result_flat(result_flat),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_row(b_res_row), .res_data(b_res_data),
    .res_last(b_res_last), .busy(b_busy));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int wval(input int mode, input int i);
    int r, c;
    r = i / COLS;
    c = i % COLS;
    return (mode == 0) ? (r + c) : (c - 2 * r);
  endfunction

  function automatic int xval(input int mode, input int c);
    return (mode == 0) ? (16 - c) : (3 * c - 20);
  endfunction

  function automatic logic [COLS*DW-1:0] mkx(input int mode);
    logic [COLS*DW-1:0] v;
    int t;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      t = xval(mode, c);
      v[c*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction

  function automatic int s16(input int v);
    logic [15:0] b;
    b = v[15:0];
    return int'($signed(b));
  endfunction

  function automatic int conv8(input int v);
    int t;
    logic [7:0] b;
    t = s16(v);
`ifdef MESH_SEQ_SAT_EN
    if (t > 127) return 127;
    if (t < -128) return -128;
    return t;
`else
    b = t[7:0];
    return int'($signed(b));
`endif
  endfunction

  // Reference model: phase of the job plus what the streams must carry.
  int ph, n, wc, idx;
  logic [COLS*DW-1:0] x_lat;
  int wq [NW];
  int er [ROWS];
  bit pv_e, st_e;
  int pa_e, pd_e;

  initial begin
    ph = 0; n = 0; wc = 0; idx = 0; x_lat = '0; pv_e = 0; st_e = 0; pa_e = 0; pd_e = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ph = 0; idx = 0; x_lat = '0; pv_e = 0; st_e = 0;
      end else begin
        pv_e = 0;
        st_e = 0;
        case (ph)
          0: if (cmd_valid) begin x_lat = cmd_x; n = 0; ph = 1; end
          1: if (w_valid) begin
               pv_e = 1; pa_e = n; pd_e = int'($signed(w_data)); wq[n] = pd_e; n++;
               if (n == NW) ph = 2;
             end
          2: begin
               st_e = 1; ph = 3; wc = 0;
               for (int r = 0; r < ROWS; r++) begin
                 er[r] = 0;
                 for (int c = 0; c < COLS; c++)
                   er[r] += wq[r*COLS + c] * int'($signed(x_lat[c*DW +: DW]));
               end
             end
          3: begin wc++; if (wc == COMP_LAT + 1) begin ph = 4; idx = 0; end end
          default: if (res_ready) begin
               if (idx == ROWS - 1) begin ph = 0; idx = 0; end else idx++;
             end
        endcase
      end
    end
  end

  // Mesh stub: stores preloads, computes on start, shows junk until the latency has elapsed.
  int mw [NW];
  logic [ROWS*ACC_W-1:0] mr;
  int mcnt;
  initial begin
    int s;
    result_flat = '0;
    mcnt = 0;
    mr = '0;
    forever begin
      @(posedge clk);
      if (preload_valid) mw[preload_addr] = int'($signed(preload_data));
      if (start) begin
        for (int r = 0; r < ROWS; r++) begin
          s = 0;
          for (int c = 0; c < COLS; c++) s += mw[r*COLS + c] * int'($signed(x_vector_flat[c*DW +: DW]));
          mr[r*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        result_flat <= {ROWS{16'hDEAD}};
        mcnt = COMP_LAT - 1;
      end else if (mcnt > 0) begin
        if (mcnt == 1) result_flat <= mr;
        mcnt--;
      end
    end
  end

  int cyc, pv_cnt, first_pv_cyc, last_pv_cyc, start_cnt, start_cyc, first_rv_cyc, beats;
  int got16 [ROWS];
  int got8 [ROWS];
  bit last_ok;

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("cmd_ready", cmd_ready, ph == 0);
        chk("w_ready", w_ready, ph == 1);
        chk("busy", busy, ph != 0);
        chk("preload_valid", preload_valid, pv_e);
        if (pv_e) begin
          chk("preload_addr", preload_addr, pa_e);
          chk("preload_data", $signed(preload_data), pd_e);
        end
        chk("start", start, st_e);
        chk("x_vector_flat", x_vector_flat == x_lat, 1);
        chk("res_valid", res_valid, ph == 4);
        if (ph == 4) begin
          chk("res_row", res_row, idx);
          chk("res_data", $signed(res_data), s16(er[idx]));
          chk("res_last", res_last, idx == ROWS - 1);
          chk("res_data_8b", $signed(b_res_data), conv8(er[idx]));
        end
        if (preload_valid) begin
          if (pv_cnt == 0) first_pv_cyc = cyc;
          pv_cnt++;
          last_pv_cyc = cyc;
        end
        if (start) begin start_cnt++; start_cyc = cyc; end
        if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (res_valid && res_ready) begin
          got16[res_row] = int'($signed(res_data));
          got8[res_row]  = int'($signed(b_res_data));
          if (res_last && res_row == 3'd7) last_ok = 1;
          beats++;
        end
      end
    end
  end

  task automatic run_job(input int mode, input bit stall, input bit bp, input bit poke, input int abort_at);
    bit bp_done;
    bp_done = 0;
    pv_cnt = 0; start_cnt = 0; first_rv_cyc = -1; beats = 0; last_ok = 0;
    first_pv_cyc = -1; last_pv_cyc = -1; start_cyc = -1;
    for (int r = 0; r < ROWS; r++) begin got16[r] = -99999; got8[r] = -99999; end
    @(posedge clk); #1;
    cmd_x = mkx(mode); cmd_valid = 1; w_valid = 1; w_data = 8'h77;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_x = ~cmd_x;
    for (int i = 0; i < NW; i++) begin
      if (i == abort_at) return;
      w_valid = 1;
      w_data = DW'(wval(mode, i));
      @(posedge clk); #1;
      w_valid = 0;
      w_data = 8'h5A;
      if (stall) repeat (2) begin @(posedge clk); #1; end
    end
    for (int t = 0; t < 400 && beats < ROWS; t++) begin
      @(posedge clk); #1;
      if (poke && t == 10) begin cmd_valid = 1; cmd_x = mkx(1); end
      if (poke && t == 11) cmd_valid = 0;
      if (bp && !bp_done && res_valid && res_row == 3'd3) begin
        res_ready = 0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          chk("bp_hold_row", res_row, 3);
          chk("bp_hold_data", $signed(res_data), 1088);
        end
        res_ready = 1;
        bp_done = 1;
      end
    end
    if (beats < ROWS) chk("drain_timeout_beats", beats, ROWS);
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_preload_beats"}, pv_cnt, NW);
    chk({tag, "_start_once"}, start_cnt, 1);
    chk({tag, "_start_after_last"}, start_cyc - last_pv_cyc, 1);
    chk({tag, "_res_latency"}, first_rv_cyc - start_cyc, COMP_LAT + 1);
    chk({tag, "_beats"}, beats, ROWS);
    chk({tag, "_last_row7"}, last_ok, 1);
    for (int r = 0; r < ROWS; r++) chk({tag, "_row_result"}, got16[r], 680 + 136 * r);
`ifdef MESH_SEQ_SAT_EN
    for (int r = 0; r < ROWS; r++) chk({tag, "_row_8b_sat"}, got8[r], 127);
`else
    chk({tag, "_row0_8b"}, got8[0], -88);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_preload_valid"}, preload_valid, 0);
    chk({tag, "_preload_addr"}, preload_addr, 0);
    chk({tag, "_preload_data"}, preload_data, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_x_vector_zero"}, x_vector_flat == '0, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_row"}, res_row, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_last"}, res_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_w_ready"}, w_ready, 0);
  endtask

  initial begin
    cmd_valid = 0; w_valid = 0; w_data = '0; cmd_x = '0; res_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);

    run_job(0, 0, 0, 0, -1);
    check_nominal("nom");

    run_job(1, 1, 0, 0, -1);
    chk("stall_preload_beats", pv_cnt, NW);
    chk("stall_load_span", last_pv_cyc - first_pv_cyc, 3 * (NW - 1));
    chk("stall_start_after_last", start_cyc - last_pv_cyc, 1);
    chk("stall_beats", beats, ROWS);

    run_job(0, 0, 1, 1, -1);
    check_nominal("bp");

    run_job(0, 0, 0, 0, 40);
    rst_n = 0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    run_job(0, 0, 0, 0, -1);
    check_nominal("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
